// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with write bypass, optional zero register
// and a per-register busy scoreboard for decode stall decisions.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic              w_wr_ok;

    assign w_wr_ok  = we && !((ZERO_REG != 0) && (waddr == '0));
    assign busy_cnt = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr_ok) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Reserve is applied after clear so a new producer wins the same slot.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            if (we) w_busy_nxt[waddr] = 1'b0;
            if (rsv_en) w_busy_nxt[rsv_addr] = 1'b1;
            if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt_nxt = w_cnt_nxt + (ADDR_W+1)'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_zero;
        logic              w_byp;

        assign w_ra   = raddr[k*ADDR_W +: ADDR_W];
        assign w_zero = (ZERO_REG != 0) && (w_ra == '0);
        assign w_byp  = we && (waddr == w_ra);

        assign rdata[k*DATA_W +: DATA_W] =
            (!rst_n || w_zero) ? '0 :
            w_byp              ? wdata :
                                 r_mem[w_ra];
        assign rbusy[k] = rst_n & r_busy[w_ra];
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a default build and a
// four-port 16-bit build without the zero register.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;
    logic [5:0]  busy_cnt;

    logic [19:0] b_raddr;
    logic [63:0] b_rdata;
    logic [3:0]  b_rbusy;
    logic [5:0]  b_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_scoreboard u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr    (raddr),
        .rdata    (rdata),
        .rbusy    (rbusy),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    regfile_scoreboard #(
        .DATA_W   (16),
        .ADDR_W   (5),
        .NUM_RD   (4),
        .ZERO_REG (0)
    ) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr    (b_raddr),
        .rdata    (b_rdata),
        .rbusy    (b_rbusy),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata[15:0]),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .busy_cnt (b_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0;
        rsv_en = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        raddr = '0; b_raddr = '0;
        we = 1'b0; waddr = '0; wdata = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;

        // reset, with a bypass attempt that must stay hidden
        #1 rst_n = 1'b0;
        raddr = {5'd1, 5'd1};
        we = 1'b1; waddr = 5'd1; wdata = 32'h5;
        #1;
        chk("rst_rdata", rdata, 64'h0);
        chk("rst_rbusy", {62'h0, rbusy}, 64'h0);
        chk("rst_cnt", {58'h0, busy_cnt}, 64'h0);
        tick(); tick();
        idle(); rst_n = 1'b1;
        #1;
        chk("r1_after_rst", rdata, 64'h0);

        // write r1 with bypass, then hold
        we = 1'b1; waddr = 5'd1; wdata = 32'h2;
        #1 chk("r1_bypass", rdata[31:0], 64'h2);
        tick(); idle();
        #1 chk("r1_hold", rdata, {32'h2, 32'h2});

        // zero register ignores write and reserve
        raddr = {5'd1, 5'd0};
        we = 1'b1; waddr = 5'd0; wdata = 32'hDEADBEEF;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        #1 chk("r0_bypass", rdata[31:0], 64'h0);
        tick(); idle();
        #1;
        chk("r0_read", rdata[31:0], 64'h0);
        chk("r0_busy", {63'h0, rbusy[0]}, 64'h0);
        chk("r0_cnt", {58'h0, busy_cnt}, 64'h0);

        // reserve r5, then write it back
        raddr = {5'd1, 5'd5};
        rsv_en = 1'b1; rsv_addr = 5'd5;
        #1 chk("r5_busy_nobyp", {63'h0, rbusy[0]}, 64'h0);
        tick(); idle();
        #1;
        chk("r5_busy", {63'h0, rbusy[0]}, 64'h1);
        chk("r5_cnt1", {58'h0, busy_cnt}, 64'h1);
        we = 1'b1; waddr = 5'd5; wdata = 32'h7;
        #1;
        chk("r5_wr_byp", rdata[31:0], 64'h7);
        chk("r5_wr_busy", {63'h0, rbusy[0]}, 64'h1);
        tick(); idle();
        #1;
        chk("r5_clr_busy", {63'h0, rbusy[0]}, 64'h0);
        chk("r5_clr_cnt", {58'h0, busy_cnt}, 64'h0);
        chk("r5_data", rdata[31:0], 64'h7);

        // r9 busy, then reserve and write together
        raddr = {5'd9, 5'd5};
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick(); idle();
        #1 chk("r9_cnt1", {58'h0, busy_cnt}, 64'h1);
        rsv_en = 1'b1; rsv_addr = 5'd9;
        we = 1'b1; waddr = 5'd9; wdata = 32'h99;
        tick(); idle();
        #1;
        chk("r9_data", rdata[63:32], 64'h99);
        chk("r9_busy", {63'h0, rbusy[1]}, 64'h1);
        chk("r9_cnt", {58'h0, busy_cnt}, 64'h1);
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick(); idle();
        #1 chk("r9_rsv_again", {58'h0, busy_cnt}, 64'h1);
        we = 1'b1; waddr = 5'd9; wdata = 32'h99;
        tick(); idle();
        #1 chk("r9_clr_cnt", {58'h0, busy_cnt}, 64'h0);

        // flush beats a same-cycle reserve and clear
        rsv_en = 1'b1; rsv_addr = 5'd3; tick();
        rsv_addr = 5'd4; tick();
        rsv_addr = 5'd6; tick();
        idle();
        #1 chk("fl_cnt3", {58'h0, busy_cnt}, 64'h3);
        flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd7;
        we = 1'b1; waddr = 5'd4; wdata = 32'h44;
        tick(); idle();
        raddr = {5'd3, 5'd7};
        #1;
        chk("fl_busy", {62'h0, rbusy}, 64'h0);
        chk("fl_cnt0", {58'h0, busy_cnt}, 64'h0);
        raddr = {5'd4, 5'd6};
        #1;
        chk("fl_busy46", {62'h0, rbusy}, 64'h0);
        chk("fl_r4_data", rdata[63:32], 64'h44);

        // top index, both ports on the same register
        raddr = {5'd31, 5'd31};
        rsv_en = 1'b1; rsv_addr = 5'd31;
        tick(); idle();
        we = 1'b1; waddr = 5'd31; wdata = 32'hFFFF_FFFF;
        rsv_en = 1'b1; rsv_addr = 5'd2;
        tick(); idle();
        #1;
        chk("r31_same", rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("r31_busy", {62'h0, rbusy}, 64'h0);
        chk("r2_cnt", {58'h0, busy_cnt}, 64'h1);

        // four-port build, ZERO_REG=0 so r0 kept the low half of DEADBEEF
        b_raddr = {5'd31, 5'd9, 5'd5, 5'd0};
        #1 chk("b4_distinct", b_rdata, 64'hFFFF_0099_0007_BEEF);
        b_raddr = {5'd5, 5'd5, 5'd4, 5'd1};
        #1 chk("b4_same", b_rdata, 64'h0007_0007_0044_0002);

        // async reset mid-cycle with r2 busy
        we = 1'b1; waddr = 5'd2; wdata = 32'h22;
        tick(); idle();
        raddr = {5'd5, 5'd2};
        #1;
        chk("r2_pre_data", rdata[31:0], 64'h22);
        chk("r2_pre_busy", {63'h0, rbusy[0]}, 64'h0);
        rsv_en = 1'b1; rsv_addr = 5'd2;
        tick(); idle();
        #1 chk("r2_busy", {63'h0, rbusy[0]}, 64'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_rdata", rdata, 64'h0);
        chk("ar_rbusy", {62'h0, rbusy}, 64'h0);
        chk("ar_cnt", {58'h0, busy_cnt}, 64'h0);
        chk("ar_b4", b_rdata, 64'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("ar_lost", rdata, 64'h0);
        chk("ar_lost_busy", {62'h0, rbusy}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
